bisr_result_merger_os: RTL and testbench

Consumer end of the output-stationary BISR datapath. Captures the drained systolic results from the array's bottom edge and the recompute-unit (RU) results, then overwrites every faulty PE's entry with its RU value. Once collection is complete, it streams the corrected ROWS x COLS result matrix to the host one row per valid/ready beat. It sits after the systolic array and recompute module in the BISR top level, and is driven by the STW fault map and the RU coordinate mapping.

---
 rtl/bisr_pkg.sv | 17 +
 rtl/bisr_ru_capture.sv | 46 ++++
 rtl/bisr_result_merger_os.sv | 135 +++++++++++++
 tb/tb_bisr_result_merger_os.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bisr_pkg.sv
// bisr_pkg: shared FSM state type, index-width helper and popcount for the BISR datapath.
package bisr_pkg;
    localparam int POP_W = 256;

    typedef enum logic [1:0] {IDLE, COLLECT, STREAM} state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] popcount(input logic [POP_W-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < POP_W; i++) n += 32'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/bisr_ru_capture.sv
// bisr_ru_capture: per-RU capture mask and priority-resolved buffer writes (lower RU index wins).
module bisr_ru_capture #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int WORD_SIZE = 16,
    parameter int NUM_RU = 4,
    parameter int RB = 2,
    parameter int CB = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              enable,
    input  logic [NUM_RU-1:0]                 ru_output_valid,
    input  logic [NUM_RU*WORD_SIZE-1:0]       rcm_bottom_out,
    input  logic [NUM_RU*RB-1:0]              ru_row_mapping,
    input  logic [NUM_RU*CB-1:0]              ru_col_mapping,
    output logic [NUM_RU-1:0]                 captured,
    output logic [ROWS*COLS-1:0]              wr_en,
    output logic [ROWS*COLS*WORD_SIZE-1:0]    wr_data
);
    logic [NUM_RU-1:0] take;

    assign take = enable ? (ru_output_valid & ~captured) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) captured <= '0;
        else if (clear) captured <= '0;
        else if (enable) captured <= captured | ru_output_valid;
    end

    // Out-of-range coordinates never match an entry, so they capture without writing.
    always_comb begin
        wr_en = '0;
        wr_data = '0;
        for (int e = 0; e < ROWS*COLS; e++) begin
            for (int i = NUM_RU-1; i >= 0; i--) begin
                if (take[i] && int'(ru_row_mapping[i*RB +: RB]) == e / COLS &&
                    int'(ru_col_mapping[i*CB +: CB]) == e % COLS) begin
                    wr_en[e] = 1'b1;
                    wr_data[e*WORD_SIZE +: WORD_SIZE] = rcm_bottom_out[i*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
    end
endmodule

// File: rtl/bisr_result_merger_os.sv
// bisr_result_merger_os: merges drained systolic rows with RU results and streams the corrected matrix.
// Optional collection watchdog enabled by BISR_MERGE_TIMEOUT_EN.
module bisr_result_merger_os import bisr_pkg::*; #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int WORD_SIZE = 16,
    parameter int NUM_RU = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int RB = idx_w(ROWS),
    localparam int CB = idx_w(COLS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          matrix_start,
    input  logic [ROWS*COLS-1:0]          fault_map,
    input  logic                          drain_valid,
    input  logic [COLS*WORD_SIZE-1:0]     systolic_bottom_out,
    input  logic [NUM_RU-1:0]             ru_output_valid,
    input  logic [NUM_RU*WORD_SIZE-1:0]   rcm_bottom_out,
    input  logic [NUM_RU*RB-1:0]          ru_row_mapping,
    input  logic [NUM_RU*CB-1:0]          ru_col_mapping,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COLS*WORD_SIZE-1:0]     out_data,
    output logic [RB-1:0]                 out_row,
    output logic                          out_last,
    output logic                          done,
    output logic                          uncorrectable,
    output logic                          timeout_flag
);
    localparam int N = ROWS*COLS;

    state_t state;
    logic [RB:0] drain_cnt;
    logic [31:0] expected, fault_cnt;
    logic [N-1:0] patched, ru_we;
    logic [N*WORD_SIZE-1:0] ru_wd;
    logic [NUM_RU-1:0] captured;
    logic [WORD_SIZE-1:0] mem [N];
    logic start, collect, drain_we, handshake, collected, to_fire;

    assign start = state == IDLE && matrix_start;
    assign collect = state == COLLECT;
    assign drain_we = collect && drain_valid && int'(drain_cnt) < ROWS;
    assign fault_cnt = popcount(POP_W'(fault_map));
    assign collected = int'(drain_cnt) == ROWS && popcount(POP_W'(captured)) >= expected;
    assign out_valid = state == STREAM;
    assign out_last = out_valid && int'(out_row) == ROWS-1;
    assign handshake = out_valid && out_ready;

    always_comb begin
        out_data = '0;
        for (int c = 0; c < COLS; c++) out_data[c*WORD_SIZE +: WORD_SIZE] = mem[int'(out_row)*COLS + c];
    end

    bisr_ru_capture #(
        .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WORD_SIZE), .NUM_RU(NUM_RU), .RB(RB), .CB(CB)
    ) u_capture (
        .clk(clk),
        .rst(rst),
        .clear(start),
        .enable(collect),
        .ru_output_valid(ru_output_valid),
        .rcm_bottom_out(rcm_bottom_out),
        .ru_row_mapping(ru_row_mapping),
        .ru_col_mapping(ru_col_mapping),
        .captured(captured),
        .wr_en(ru_we),
        .wr_data(ru_wd)
    );

`ifdef BISR_MERGE_TIMEOUT_EN
    localparam int TW = idx_w(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tcnt <= '0;
        else if (start) tcnt <= '0;
        else if (collect && int'(tcnt) < TIMEOUT_CYCLES-1) tcnt <= tcnt + 1'b1;
    end

    // Only give up on missing RU results; an incomplete drain keeps us waiting.
    assign to_fire = collect && int'(tcnt) >= TIMEOUT_CYCLES-1 && int'(drain_cnt) == ROWS && !collected;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES > 0;
    assign to_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            drain_cnt <= '0;
            expected <= '0;
            patched <= '0;
            out_row <= '0;
            done <= 1'b0;
            uncorrectable <= 1'b0;
            timeout_flag <= 1'b0;
            for (int e = 0; e < N; e++) mem[e] <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                expected <= (fault_cnt > 32'(NUM_RU)) ? 32'(NUM_RU) : fault_cnt;
                uncorrectable <= fault_cnt > 32'(NUM_RU);
                patched <= '0;
                drain_cnt <= '0;
                timeout_flag <= 1'b0;
                state <= COLLECT;
            end
            if (collect) begin
                patched <= patched | ru_we;
                if (drain_we) drain_cnt <= drain_cnt + 1'b1;
                if (collected) state <= STREAM;
                else if (to_fire) begin
                    timeout_flag <= 1'b1;
                    state <= STREAM;
                end
            end
            if (handshake) begin
                out_row <= out_last ? '0 : out_row + 1'b1;
                if (out_last) begin
                    done <= 1'b1;
                    state <= IDLE;
                end
            end
            // Same-cycle RU writes beat the drain; earlier RU writes are protected by patched.
            for (int e = 0; e < N; e++) begin
                if (ru_we[e]) mem[e] <= ru_wd[e*WORD_SIZE +: WORD_SIZE];
                else if (drain_we && e / COLS == ROWS-1-int'(drain_cnt) && !patched[e])
                    mem[e] <= systolic_bottom_out[(e % COLS)*WORD_SIZE +: WORD_SIZE];
            end
        end
    end
endmodule

// File: tb/tb_bisr_result_merger_os.sv
// tb_bisr_result_merger_os: directed scoreboard bench for the BISR result merger.
module tb_bisr_result_merger_os;
    logic clk = 0, rst = 1, matrix_start = 0, drain_valid = 0, out_ready = 0;
    logic [15:0] fault_map = '0;
    logic [63:0] systolic_bottom_out = '0, rcm_bottom_out = '0, out_data;
    logic [3:0] ru_output_valid = '0;
    logic [7:0] ru_row_mapping = '0, ru_col_mapping = '0;
    logic out_valid, out_last, done, uncorrectable, timeout_flag;
    logic [1:0] out_row;

    typedef struct packed {logic [1:0] row; logic [63:0] data;} exp_t;
    exp_t q[$];
    logic [15:0] sys [16];
    logic [15:0] expm [16];
    int checks = 0, failures = 0;

    bisr_result_merger_os #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .matrix_start(matrix_start), .fault_map(fault_map),
        .drain_valid(drain_valid), .systolic_bottom_out(systolic_bottom_out),
        .ru_output_valid(ru_output_valid), .rcm_bottom_out(rcm_bottom_out),
        .ru_row_mapping(ru_row_mapping), .ru_col_mapping(ru_col_mapping),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_last(out_last), .done(done), .uncorrectable(uncorrectable), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] row_of(input logic [15:0] a [16], input int r);
        logic [63:0] v;
        for (int c = 0; c < 4; c++) v[c*16 +: 16] = a[r*4 + c];
        return v;
    endfunction

    task automatic fill(input logic [15:0] base, input int step);
        for (int e = 0; e < 16; e++) begin
            sys[e] = base + 16'(e * step);
            expm[e] = sys[e];
        end
    endtask

    task automatic start_job(input logic [15:0] fm);
        @(negedge clk);
        matrix_start = 1;
        fault_map = fm;
        @(negedge clk);
        matrix_start = 0;
    endtask

    task automatic drain(input int ru_beat, input logic [3:0] ruv, input logic [63:0] rud);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drain_valid = 1;
            systolic_bottom_out = row_of(sys, 3 - k);
            ru_output_valid = (k == ru_beat) ? ruv : 4'b0;
            rcm_bottom_out = rud;
        end
        @(negedge clk);
        drain_valid = 0;
        ru_output_valid = 0;
    endtask

    task automatic push_exp();
        for (int r = 0; r < 4; r++) q.push_back('{row: 2'(r), data: row_of(expm, r)});
    endtask

    task automatic stream(input logic [7:0] pat, input int npat);
        int cyc = 0;
        int guard = 0;
        while (q.size() > 0 && guard < 64) begin
            @(negedge clk);
            guard++;
            if (out_valid) begin
                out_ready = (cyc < npat) ? pat[cyc] : 1'b1;
                cyc++;
                check("out_row", 64'(out_row), 64'(q[0].row));
                check("out_data", out_data, q[0].data);
                check("out_last", 64'(out_last), 64'(q[0].row == 2'd3));
                if (out_ready) void'(q.pop_front());
            end
        end
        if (q.size() > 0) begin
            check("stream_rows_left", 64'(q.size()), 64'd0);
            q.delete();
        end
        @(negedge clk);
        out_ready = 0;
        check("done", 64'(done), 64'd1);
        check("idle_after_done", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        rst = 0;
        @(negedge clk);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out_row", 64'(out_row), 64'd0);
        check("rst_uncorrectable", 64'(uncorrectable), 64'd0);
        check("rst_timeout_flag", 64'(timeout_flag), 64'd0);

        // No faults: plain drain then stream.
        fill(16'h0000, 1);
        for (int e = 0; e < 16; e++) begin
            sys[e] = 16'((e / 4) * 16 + (e % 4));
            expm[e] = sys[e];
        end
        start_job(16'h0000);
        check("t1_uncorrectable", 64'(uncorrectable), 64'd0);
        drain(-1, 4'b0, 64'd0);
        check("t1_valid_1cyc", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_valid_2cyc", 64'(out_valid), 64'd1);
        push_exp();
        stream(8'hFF, 0);
        check("t1_timeout_flag", 64'(timeout_flag), 64'd0);

        // Single fault patched after drain; repeated strobe must be ignored.
        fill(16'h1000, 3);
        expm[5] = 16'hBEEF;
        ru_row_mapping = {2'd0, 2'd0, 2'd0, 2'd1};
        ru_col_mapping = {2'd0, 2'd0, 2'd0, 2'd1};
        start_job(16'h0020);
        drain(-1, 4'b0, 64'd0);
        @(negedge clk);
        ru_output_valid = 4'b0001;
        rcm_bottom_out = 64'h0000_0000_0000_BEEF;
        @(negedge clk);
        rcm_bottom_out = 64'h0000_0000_0000_DEAD;
        @(negedge clk);
        ru_output_valid = 0;
        push_exp();
        stream(8'hFF, 0);

        // Early RU write survives drain; same-cycle RU2/RU3 collide on (0,0) with the drain.
        fill(16'h2000, 5);
        expm[11] = 16'h1234;
        expm[0] = 16'hAAAA;
        ru_row_mapping = {2'd0, 2'd0, 2'd2, 2'd3};
        ru_col_mapping = {2'd0, 2'd0, 2'd3, 2'd3};
        start_job(16'h0801);
        @(negedge clk);
        ru_output_valid = 4'b0010;
        rcm_bottom_out = 64'h0000_0000_1234_0000;
        drain(3, 4'b1100, 64'hBBBB_AAAA_0000_0000);
        push_exp();
        stream(8'hFF, 0);

        // Five faults with four RUs, then a stalling host.
        fill(16'h3000, 7);
        for (int i = 0; i < 4; i++) expm[i] = 16'h0100 + 16'(i);
        ru_row_mapping = {2'd0, 2'd0, 2'd0, 2'd0};
        ru_col_mapping = {2'd3, 2'd2, 2'd1, 2'd0};
        start_job(16'h001F);
        check("t4_uncorrectable", 64'(uncorrectable), 64'd1);
        drain(-1, 4'b0, 64'd0);
        repeat (3) @(negedge clk);
        check("t4_wait_ru", 64'(out_valid), 64'd0);
        ru_output_valid = 4'b1111;
        rcm_bottom_out = 64'h0103_0102_0101_0100;
        @(negedge clk);
        ru_output_valid = 0;
        push_exp();
        stream(8'b0000_1001, 4);
        check("t4_uncorrectable_hold", 64'(uncorrectable), 64'd1);

`ifdef BISR_MERGE_TIMEOUT_EN
        // Missing RU: watchdog forces STREAM 16 cycles after start with systolic values.
        fill(16'h4000, 1);
        start_job(16'h0001);
        check("t6_uncorrectable_clr", 64'(uncorrectable), 64'd0);
        drain(-1, 4'b0, 64'd0);
        repeat (10) @(negedge clk);
        check("t6_valid_cyc15", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t6_valid_cyc16", 64'(out_valid), 64'd1);
        check("t6_timeout_flag", 64'(timeout_flag), 64'd1);
        push_exp();
        stream(8'hFF, 0);
`endif

        // Reset while streaming returns to IDLE immediately.
        fill(16'h5000, 2);
        start_job(16'h0000);
        check("t7_timeout_clr", 64'(timeout_flag), 64'd0);
        check("t7_uncorrectable_clr", 64'(uncorrectable), 64'd0);
        drain(-1, 4'b0, 64'd0);
        @(negedge clk);
        check("t7_streaming", 64'(out_valid), 64'd1);
        rst = 1;
        #1;
        check("t7_rst_valid", 64'(out_valid), 64'd0);
        check("t7_rst_row", 64'(out_row), 64'd0);
        check("t7_rst_data", out_data, 64'd0);
        @(negedge clk);
        rst = 0;

        // Fresh job after reset.
        fill(16'h6000, 9);
        start_job(16'h0000);
        drain(-1, 4'b0, 64'd0);
        push_exp();
        stream(8'hFF, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
